// File: rtl/fp_normalize_seq_if.sv
// Operand/result handshake bundle for the sequential FP normaliser.
// master drives operands and out_ready; slave is the normaliser itself.
interface fp_normalize_seq_if #(
  parameter int MW = 24,
  parameter int EW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [MW:0]   mxy1;
  logic [EW-1:0] ex;
  logic          s;
  logic          s1;
  logic          s2;
  logic          s3;
  logic          out_valid;
  logic          out_ready;
  logic          sr;
  logic [EW-1:0] exy;
  logic [MW-1:0] mxy;
  logic          zero;
  logic          underflow;
  logic          overflow;

  modport master (
    output in_valid, mxy1, ex, s, s1, s2, s3, out_ready,
    input  in_ready, out_valid, sr, exy, mxy, zero, underflow, overflow
  );

  modport slave (
    input  in_valid, mxy1, ex, s, s1, s2, s3, out_ready,
    output in_ready, out_valid, sr, exy, mxy, zero, underflow, overflow
  );
endinterface

// File: rtl/fp_normalize_seq.sv
// Sequential post-add normaliser: resolves sign/carry on accept, then left-shifts
// the mantissa up to SH positions per cycle until the hidden bit is set or exp hits 0.
module fp_normalize_seq #(
  parameter int MW = 24,
  parameter int EW = 8,
  parameter int SH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  fp_normalize_seq_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t        state_reg;
  logic          in_ready_reg;
  logic          out_valid_reg;
  logic          sr_reg;
  logic [EW-1:0] exp_reg;
  logic [MW-1:0] mant_reg;
  logic          zero_reg;
  logic          underflow_reg;
  logic          overflow_reg;

  logic          neg_in;
  logic          sr_in;
  logic [MW:0]   mag_in;
  logic          carry_in;
  logic [EW:0]   ex_inc;
  logic          mag_zero;
  logic          ovf_in;
  logic [MW-1:0] acc_mant;
  logic [EW-1:0] acc_exp;

  // Operand decode, only consumed on the accept edge
  always_comb begin
    neg_in   = bus.mxy1[MW] & bus.s3;
    sr_in    = (bus.s ? bus.s1 : bus.s2) ^ neg_in;
    mag_in   = neg_in ? ((~bus.mxy1) + {{MW{1'b0}}, 1'b1}) : bus.mxy1;
    carry_in = ~neg_in & mag_in[MW];
    ex_inc   = {1'b0, bus.ex} + {{EW{1'b0}}, 1'b1};
    mag_zero = (mag_in == '0);
    ovf_in   = carry_in && (ex_inc >= {1'b0, {EW{1'b1}}});
    acc_mant = carry_in ? mag_in[MW:1] : mag_in[MW-1:0];
    acc_exp  = carry_in ? ex_inc[EW-1:0] : bus.ex;
  end

  int            lz;
  int            sh;
  logic [MW-1:0] mant_shift;
  logic [EW-1:0] exp_next;

  // Shift is capped by the per-cycle limit and by the exponent so it never wraps
  always_comb begin
    lz = MW;
    for (int i = 0; i < MW; i++) begin
      if (mant_reg[i]) lz = MW - 1 - i;
    end
    sh = lz;
    if (sh > SH) sh = SH;
    if (sh > int'(exp_reg)) sh = int'(exp_reg);
    mant_shift = mant_reg << sh;
    exp_next   = exp_reg - EW'(sh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      sr_reg        <= 1'b0;
      exp_reg       <= '0;
      mant_reg      <= '0;
      zero_reg      <= 1'b0;
      underflow_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          in_ready_reg <= 1'b1;
          if (bus.in_valid && in_ready_reg) begin
            in_ready_reg  <= 1'b0;
            zero_reg      <= 1'b0;
            underflow_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            sr_reg        <= sr_in;
            if (mag_zero) begin
              sr_reg        <= 1'b0;
              mant_reg      <= '0;
              exp_reg       <= '0;
              zero_reg      <= 1'b1;
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end else if (ovf_in) begin
              mant_reg      <= '0;
              exp_reg       <= '1;
              overflow_reg  <= 1'b1;
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end else begin
              mant_reg  <= acc_mant;
              exp_reg   <= acc_exp;
              state_reg <= NORM;
            end
          end
        end
        NORM: begin
          mant_reg <= mant_shift;
          exp_reg  <= exp_next;
          if (mant_shift[MW-1] || (exp_next == '0)) begin
            underflow_reg <= ~mant_shift[MW-1] && (exp_next == '0);
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.sr        = sr_reg;
  assign bus.exy       = exp_reg;
  assign bus.mxy       = mant_reg;
  assign bus.zero      = zero_reg;
  assign bus.underflow = underflow_reg;
  assign bus.overflow  = overflow_reg;

endmodule

// File: tb/tb_fp_normalize_seq.sv
// Self-checking bench for fp_normalize_seq (MW=24, EW=8, SH=4): directed cases,
// backpressure, reset abort and random operands against an arithmetic model.
module tb_fp_normalize_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  fp_normalize_seq_if #(.MW(24), .EW(8)) bus ();

  fp_normalize_seq #(.MW(24), .EW(8), .SH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] m1;
    logic [7:0]  ex;
    logic [3:0]  ss;   // {s, s1, s2, s3}
    logic [35:0] res;  // {sr, exy, mxy, zero, underflow, overflow}
    int          lat;
  } dcase_t;

  function automatic logic [35:0] obs_res();
    return {bus.sr, bus.exy, bus.mxy, bus.zero, bus.underflow, bus.overflow};
  endfunction

  // Reference: value-level arithmetic on integers, counting one edge per normalise step
  function automatic void model(input logic [24:0] m1, input logic [7:0] ex,
                                input logic [3:0] ss,
                                output logic [35:0] res, output int lat);
    longint mag, mant;
    int     e, lz, sh;
    logic   neg, sg, uf;
    neg = m1[24] & ss[0];
    sg  = (ss[3] ? ss[2] : ss[1]) ^ neg;
    mag = neg ? (((longint'(1) << 25) - longint'(m1)) % (longint'(1) << 25)) : longint'(m1);
    if (mag == 0) begin
      res = {1'b0, 8'h00, 24'h000000, 3'b100};
      lat = 1;
      return;
    end
    if (!neg && mag >= (longint'(1) << 24)) begin
      mant = mag / 2;
      e    = int'(ex) + 1;
      if (e >= 255) begin
        res = {sg, 8'hFF, 24'h000000, 3'b001};
        lat = 1;
        return;
      end
    end else begin
      mant = mag % (longint'(1) << 24);
      e    = int'(ex);
    end
    lat = 1;
    do begin
      lz = 0;
      while (lz < 24 && mant < (longint'(1) << (23 - lz))) lz++;
      sh = lz;
      if (sh > 4) sh = 4;
      if (sh > e) sh = e;
      mant = mant << sh;
      e    = e - sh;
      lat++;
    end while (mant < (longint'(1) << 23) && e != 0);
    uf  = (mant < (longint'(1) << 23)) && (e == 0);
    res = {sg, e[7:0], mant[23:0], 1'b0, uf, 1'b0};
  endfunction

  task automatic scramble_inputs();
    bus.mxy1 = 25'($urandom);
    bus.ex   = 8'($urandom);
    {bus.s, bus.s1, bus.s2, bus.s3} = 4'($urandom);
  endtask

  // Waits for in_ready, presents one operand for exactly the accept edge
  task automatic start_op(input logic [24:0] m1, input logic [7:0] ex, input logic [3:0] ss);
    for (int i = 0; i < 50 && bus.in_ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL accept_timeout in_ready=%b required 1", bus.in_ready);
    end
    bus.mxy1 = m1;
    bus.ex   = ex;
    {bus.s, bus.s1, bus.s2, bus.s3} = ss;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    scramble_inputs();
  endtask

  // Latency counts the accept edge as 1; -1 means out_valid never arrived
  task automatic wait_done(output int lat);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (bus.out_valid !== 1'b1) lat = -1;
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    scramble_inputs();
    #12;
    checks++;
    if ({bus.in_ready, bus.out_valid, obs_res()} !== 38'd0) begin
      failures++;
      $display("FAIL reset_state got=%h required 0", {bus.in_ready, bus.out_valid, obs_res()});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_before_edge got=%b required 0", bus.in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_release got=%b required 1", bus.in_ready);
    end
    $display("reset: in_ready=%b out_valid=%b", bus.in_ready, bus.out_valid);
  endtask

  task automatic test_directed();
    dcase_t      tc [6];
    logic [35:0] got;
    int          lat;
    tc[0] = '{25'h0800000, 8'h80, 4'b0000, {1'b0, 8'h80, 24'h800000, 3'b000}, 2};
    tc[1] = '{25'h1800000, 8'h7F, 4'b0000, {1'b0, 8'h80, 24'hC00000, 3'b000}, 2};
    tc[2] = '{25'h1800000, 8'hFE, 4'b0000, {1'b0, 8'hFF, 24'h000000, 3'b001}, 1};
    tc[3] = '{25'h1FFFFF0, 8'h80, 4'b1001, {1'b1, 8'h6D, 24'h800000, 3'b000}, 6};
    tc[4] = '{25'h0000000, 8'h33, 4'b1101, {1'b0, 8'h00, 24'h000000, 3'b100}, 1};
    tc[5] = '{25'h0000010, 8'h05, 4'b0000, {1'b0, 8'h00, 24'h000200, 3'b010}, 3};
    for (int i = 0; i < 6; i++) begin
      start_op(tc[i].m1, tc[i].ex, tc[i].ss);
      wait_done(lat);
      got = obs_res();
      $display("directed %0d: mxy1=%h ex=%h res=%h lat=%0d", i, tc[i].m1, tc[i].ex, got, lat);
      checks++;
      if (got !== tc[i].res) begin
        failures++;
        $display("FAIL directed_%0d_result got=%h required %h", i, got, tc[i].res);
      end
      checks++;
      if (lat != tc[i].lat) begin
        failures++;
        $display("FAIL directed_%0d_latency got=%0d required %0d", i, lat, tc[i].lat);
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    logic [35:0] exp_res, held;
    int          exp_lat, lat;
    model(25'h1FFFFF0, 8'h80, 4'b1001, exp_res, exp_lat);
    start_op(25'h1FFFFF0, 8'h80, 4'b1001);
    // Competing operand offered while normalising must be dropped
    bus.in_valid = 1'b1;
    bus.mxy1 = 25'h0000001;
    bus.ex = 8'h10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_done(lat);
    lat = lat + 2;
    held = obs_res();
    checks++;
    if (held !== exp_res || lat != exp_lat) begin
      failures++;
      $display("FAIL bp_result got=%h/%0d required %h/%0d", held, lat, exp_res, exp_lat);
    end
    for (int c = 0; c < 5; c++) begin
      if (c == 2) bus.in_valid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({bus.out_valid, bus.in_ready, obs_res()} !== {2'b10, exp_res}) begin
        failures++;
        $display("FAIL bp_hold_%0d got=%h required %h", c,
                 {bus.out_valid, bus.in_ready, obs_res()}, {2'b10, exp_res});
      end
    end
    bus.in_valid = 1'b0;
    $display("backpressure: res=%h lat=%0d", held, lat);
    release_out();
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL bp_release got=%b required 01", {bus.out_valid, bus.in_ready});
    end
  endtask

  task automatic test_reset_mid_norm();
    logic [35:0] got;
    int          lat;
    start_op(25'h1FFFFF0, 8'h80, 4'b1001);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, obs_res()} !== 38'd0) begin
      failures++;
      $display("FAIL reset_mid_norm got=%h required 0", {bus.in_ready, bus.out_valid, obs_res()});
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_op(25'h0800000, 8'h80, 4'b0000);
    wait_done(lat);
    got = obs_res();
    $display("after_reset: res=%h lat=%0d", got, lat);
    checks++;
    if (got !== {1'b0, 8'h80, 24'h800000, 3'b000} || lat != 2) begin
      failures++;
      $display("FAIL after_reset_op got=%h/%0d required %h/2", got, lat,
               {1'b0, 8'h80, 24'h800000, 3'b000});
    end
    release_out();
  endtask

  task automatic test_random();
    logic [24:0] m1;
    logic [7:0]  ex;
    logic [3:0]  ss;
    logic [35:0] exp_res, got;
    int          exp_lat, lat;
    for (int n = 0; n < 150; n++) begin
      m1 = 25'($urandom);
      m1 = m1 >> $urandom_range(0, 25);
      ex = 8'($urandom);
      if ($urandom_range(0, 3) == 0) ex = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 7) == 0) ex = 8'($urandom_range(252, 255));
      ss = 4'($urandom);
      model(m1, ex, ss, exp_res, exp_lat);
      start_op(m1, ex, ss);
      wait_done(lat);
      got = obs_res();
      $display("random %0d: mxy1=%h ex=%h ss=%b res=%h lat=%0d", n, m1, ex, ss, got, lat);
      checks++;
      if (got !== exp_res || lat != exp_lat) begin
        failures++;
        $display("FAIL random_%0d got=%h/%0d required %h/%0d", n, got, lat, exp_res, exp_lat);
      end
      release_out();
    end
  endtask

  task automatic test_back_to_back();
    logic [35:0] exp_res, got;
    int          exp_lat, lat;
    logic [24:0] m1;
    for (int n = 0; n < 8; n++) begin
      m1 = 25'h0FFFFFF >> (n * 3);
      model(m1, 8'h40, 4'b0101, exp_res, exp_lat);
      start_op(m1, 8'h40, 4'b0101);
      wait_done(lat);
      got = obs_res();
      $display("b2b %0d: mxy1=%h res=%h lat=%0d", n, m1, got, lat);
      checks++;
      if (got !== exp_res || lat != exp_lat) begin
        failures++;
        $display("FAIL b2b_%0d got=%h/%0d required %h/%0d", n, got, lat, exp_res, exp_lat);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_norm();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_normalize_seq.md
FP_NORMALIZE_SEQ -- requirements
Module: fp_normalize_seq

Interface
REQ-001 Parameter MW, default 24: mantissa width including hidden bit.
REQ-002 Parameter EW, default 8: exponent width.
REQ-003 Parameter SH, default 4: maximum left-shift positions per normalise cycle, with 1 <= SH <= MW.
REQ-004 Ports: one clock; reset asynchronous, active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 in_valid  in  1  input operand valid.
REQ-008 in_ready  out  1  block can accept an operand.
REQ-009 mxy1  in  MW+1  raw adder sum; bit MW is carry/sign.
REQ-010 ex  in  EW  pre-normalisation exponent.
REQ-011 s  in  1  sign select: 1 selects s1, 0 selects s2.
REQ-012 s1, s2  in  1 each  operand signs.
REQ-013 s3  in  1  effective subtraction.
REQ-014 out_valid  out  1  result valid.
REQ-015 out_ready  in  1  downstream accepts result.
REQ-016 sr  out  1  result sign.
REQ-017 exy  out  EW  result exponent.
REQ-018 mxy  out  MW  result mantissa.
REQ-019 zero, underflow, overflow  out  1 each  result flags, valid with out_valid.

Function
REQ-020 The FSM SHALL have three states: IDLE, NORM and DONE.
REQ-021 in_ready SHALL be 1 only in IDLE; an operand is accepted on an edge with in_valid & in_ready.
REQ-022 On accept: neg = mxy1[MW] & s3; sr = (s ? s1 : s2) ^ neg; mag = neg ? (two's complement of mxy1, MW+1 bits) : mxy1.
REQ-023 On accept, carry case (!neg & mag[MW]): mant = mag[MW:1], exp = ex+1; otherwise mant = mag[MW-1:0], exp = ex.
REQ-024 On accept, if mag == 0: mant = 0, exp = 0, sr = 0, zero = 1, next state DONE.
REQ-025 On accept, if the carry case gives exp >= 2^EW-1: exp = all ones, mant = 0, overflow = 1, next state DONE.
REQ-026 On accept, all other cases SHALL go to NORM.
REQ-027 In NORM, each edge: lz = leading zeros of mant; sh = min(lz, SH, exp); mant <<= sh; exp -= sh.
REQ-028 NORM SHALL go to DONE on the same edge when the post-shift mant[MW-1] == 1 or exp == 0; otherwise it stays in NORM.
REQ-029 underflow SHALL be set when NORM terminates with exp == 0 and mant[MW-1] == 0.
REQ-030 Latency SHALL be 1 edge for zero/overflow and 1 + max(1, ceil(lz0/SH)) edges otherwise, where lz0 is the initial leading-zero count, absent underflow clamping.
REQ-031 In DONE, out_valid = 1 and sr, exy, mxy and flags SHALL hold stable until an edge with out_ready = 1, which returns the FSM to IDLE.
REQ-032 Flags SHALL be cleared on every accept.
REQ-033 Exponent arithmetic SHALL be unsigned EW-bit and SHALL never wrap below 0.
REQ-034 in_valid outside IDLE SHALL be ignored, and the inputs SHALL be sampled only on the accept edge.

Reset
REQ-035 rst_n low SHALL force, asynchronously, state IDLE; out_valid = 0; sr, exy, mxy, zero, underflow, overflow = 0.
REQ-036 in_ready SHALL be 0 while rst_n is low and 1 from the first edge after release.
REQ-037 Reset asserted mid-NORM or mid-DONE SHALL abort the operation with no output produced.

Verification
REQ-038 Normalised, MW=24/EW=8/SH=4: mxy1=25'h0800000, ex=8'h80, s3=0 -> mxy=24'h800000, exy=8'h80, out_valid 2 edges after accept.
REQ-039 Carry: mxy1=25'h1800000, ex=8'h7F, s3=0 -> mxy=24'hC00000, exy=8'h80; same with ex=8'hFE -> exy=8'hFF, mxy=0, overflow=1, latency 1.
REQ-040 Negative subtract: mxy1=25'h1FFFFF0, s3=1, s=1, s1=0, ex=8'h80 -> sr=1, mxy=24'h800000, exy=8'h6D; shifts 4,4,4,4,3; out_valid 6 edges after accept.
REQ-041 Zero and underflow: mxy1=0 -> zero=1, exy=0, mxy=0, sr=0, latency 1; mxy1=25'h0000010, ex=8'h05 -> mxy=24'h000200, exy=0, underflow=1.
REQ-042 Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0; in_valid pulses during NORM -> ignored.
REQ-043 Reset during NORM of the REQ-040 case -> immediate IDLE, all outputs 0; the next operand processes correctly.
